// File: rtl/seq_vec_chk_pkg.sv
// rtl/seq_vec_chk_pkg.sv - shared state encoding, limits and entry sizing for seq_vec_chk
package seq_vec_chk_pkg;

    localparam int LAT_MAX = 4;
    localparam int DRAIN_W = $clog2(LAT_MAX + 1);

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Pipe entry is packed as {valid, chk, exp[NBITS_OUT], idx[CNT_W]}
    function automatic int entry_w(input int nbits_out, input int cnt_w);
        return 2 + nbits_out + cnt_w;
    endfunction

endpackage

// File: rtl/seq_vec_chk_pipe.sv
// rtl/seq_vec_chk_pipe.sv - delay line carrying vector entries to the compare stage
module seq_vec_chk_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/seq_vec_chk.sv
// rtl/seq_vec_chk.sv - applies test vectors to a sequential DUT and checks its delayed response
module seq_vec_chk
    import seq_vec_chk_pkg::*;
#(
    parameter int NBITS_IN  = 1,
    parameter int NBITS_OUT = 1,
    parameter int LAT       = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 vec_val,
    output logic                 vec_rdy,
    input  logic [NBITS_IN-1:0]  vec_a,
    input  logic [NBITS_OUT-1:0] vec_exp,
    input  logic                 vec_chk,
    input  logic                 vec_last,
    output logic [NBITS_IN-1:0]  dut_a,
    input  logic [NBITS_OUT-1:0] dut_q,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [CNT_W-1:0]     vec_idx
);

    localparam int EW = entry_w(NBITS_OUT, CNT_W);

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 accept;
    logic                 run_start;
    logic [EW-1:0]        push_entry;
    logic [EW-1:0]        cmp_entry;
    logic                 cmp_valid;
    logic                 cmp_chk;
    logic [NBITS_OUT-1:0] cmp_exp;
    logic [CNT_W-1:0]     cmp_idx;
    logic                 mismatch;

    assign accept     = (state == RUN) && vec_val;
    assign run_start  = start && ((state == IDLE) || (state == DONE));
    assign push_entry = {accept, vec_chk, vec_exp, vec_idx};

    seq_vec_chk_pipe #(
        .W     (EW),
        .DEPTH (LAT + 1)
    ) u_pipe (
        .clk   (clk),
        .rst_n (reset),
        .flush (run_start),
        .din   (push_entry),
        .dout  (cmp_entry)
    );

    assign {cmp_valid, cmp_chk, cmp_exp, cmp_idx} = cmp_entry;
    assign mismatch = cmp_valid && cmp_chk && (dut_q != cmp_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            dut_a         <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
            vec_idx       <= '0;
        end else begin
            // err_count still zero means this is the run's first mismatch
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_idx <= cmp_idx;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        err_count     <= '0;
                        vec_idx       <= '0;
                        first_err_idx <= '1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        dut_a   <= vec_a;
                        vec_idx <= vec_idx + 1'b1;
                        if (vec_last) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(LAT)) state <= DONE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vec_rdy = (state == RUN);
    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign pass    = done && (err_count == '0);

endmodule

// File: tb/tb_seq_vec_chk.sv
// tb/tb_seq_vec_chk.sv - self-checking bench for seq_vec_chk against a DFF / stuck-0 DUT model
module tb_seq_vec_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, vec_val, vec_a, vec_exp, vec_chk, vec_last, dut_q;
    logic        vec_rdy, dut_a, busy, done, pass;
    logic [15:0] err_count, first_err_idx, vec_idx;
    logic        s_vec_rdy, s_dut_a, s_busy, s_done, s_pass;
    logic [1:0]  s_err, s_first, s_idx;

    logic dff_q = 1'b0;
    bit   stuck = 1'b0;
    always @(posedge clk) dff_q <= dut_a;
    assign dut_q = stuck ? 1'b0 : dff_q;

    seq_vec_chk u_dut (
        .clk(clk), .reset(reset), .start(start), .vec_val(vec_val), .vec_rdy(vec_rdy),
        .vec_a(vec_a), .vec_exp(vec_exp), .vec_chk(vec_chk), .vec_last(vec_last),
        .dut_a(dut_a), .dut_q(dut_q), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .vec_idx(vec_idx)
    );

    seq_vec_chk #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .vec_val(vec_val), .vec_rdy(s_vec_rdy),
        .vec_a(vec_a), .vec_exp(vec_exp), .vec_chk(vec_chk), .vec_last(vec_last),
        .dut_a(s_dut_a), .dut_q(dut_q), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .first_err_idx(s_first), .vec_idx(s_idx)
    );

    int   tests = 0;
    int   fails = 0;
    logic va [64];
    logic ve [64];
    logic vc [64];
    int   lat_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vecs(input int n, input logic [31:0] a, input logic [31:0] e, input logic [31:0] c);
        for (int i = 0; i < n; i++) begin
            va[i] = a[i];
            ve[i] = e[i];
            vc[i] = c[i];
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat_obs = 0;
        while (done !== 1'b1 && lat_obs < 20) begin
            @(negedge clk);
            lat_obs++;
        end
    endtask

    task automatic run_vecs(input int n, input int bub_pct);
        int i;
        i = 0;
        while (i < n) begin
            if (int'($urandom_range(99)) < bub_pct) begin
                vec_val  = 1'b0;
                vec_last = 1'b0;
            end else begin
                vec_val  = 1'b1;
                vec_a    = va[i];
                vec_exp  = ve[i];
                vec_chk  = vc[i];
                vec_last = (i == n - 1);
                i++;
            end
            @(negedge clk);
        end
        vec_val  = 1'b0;
        vec_last = 1'b0;
        wait_done();
    endtask

    // Scoreboard: each accepted vector's response is the DUT function of its own stimulus
    task automatic model(input int n, output int e, output int f);
        logic q;
        e = 0;
        f = -1;
        for (int i = 0; i < n; i++) begin
            q = stuck ? 1'b0 : va[i];
            if (vc[i] && (ve[i] !== q)) begin
                if (f < 0) f = i;
                e++;
            end
        end
    endtask

    initial begin
        int n, e, f;
        reset = 1'b0; start = 1'b0; vec_val = 1'b0; vec_a = 1'b0;
        vec_exp = 1'b0; vec_chk = 1'b0; vec_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dut_a", 32'(dut_a), 32'h0);
        check("rst_vec_rdy", 32'(vec_rdy), 32'h0);
        check("rst_err", 32'(err_count), 32'h0);
        check("rst_first", 32'(first_err_idx), 32'hFFFF);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy_pass", 32'({busy, pass}), 32'h0);
        reset = 1'b1;

        stuck = 1'b0;
        set_vecs(7, 32'b0011000, 32'b0011000, 32'b1111110);
        start_run();
        run_vecs(7, 0);
        check("t2_latency", 32'(lat_obs), 32'd2);
        check("t2_pass", 32'(pass), 32'h1);
        check("t2_err", 32'(err_count), 32'h0);
        check("t2_first", 32'(first_err_idx), 32'hFFFF);
        check("t2_vec_idx", 32'(vec_idx), 32'd7);
        check("t2_busy", 32'(busy), 32'h0);

        stuck = 1'b1;
        set_vecs(7, 32'b0011000, 32'b0110000, 32'b1111110);
        start_run();
        run_vecs(7, 0);
        check("t3_err", 32'(err_count), 32'd2);
        check("t3_first", 32'(first_err_idx), 32'd4);
        check("t3_pass", 32'(pass), 32'h0);
        check("t3_done", 32'(done), 32'h1);

        set_vecs(7, 32'b0011000, 32'b0110000, 32'b0);
        start_run();
        check("t4_clear_err", 32'(err_count), 32'h0);
        check("t4_clear_first", 32'(first_err_idx), 32'hFFFF);
        check("t4_rdy_busy", 32'({vec_rdy, busy, done}), 32'b110);
        run_vecs(7, 0);
        check("t4_err", 32'(err_count), 32'h0);
        check("t4_pass", 32'(pass), 32'h1);

        stuck = 1'b0;
        start_run();
        vec_val = 1'b1; vec_a = 1'b1; vec_exp = 1'b0; vec_chk = 1'b1; vec_last = 1'b0;
        @(negedge clk);
        vec_val = 1'b0; vec_a = 1'b0;
        @(negedge clk);
        check("t5_hold1", 32'(dut_a), 32'h1);
        @(negedge clk);
        check("t5_hold2", 32'(dut_a), 32'h1);
        vec_val = 1'b1; vec_a = 1'b0; vec_exp = 1'b1; vec_last = 1'b1;
        @(negedge clk);
        vec_val = 1'b0; vec_last = 1'b0;
        wait_done();
        check("t5_latency", 32'(lat_obs), 32'd2);
        check("t5_err", 32'(err_count), 32'd2);
        check("t5_first", 32'(first_err_idx), 32'd0);
        check("t5_vec_idx", 32'(vec_idx), 32'd2);

        set_vecs(5, 32'b10110, 32'b01001, 32'b11111);
        start_run();
        run_vecs(5, 0);
        check("t6_err", 32'(err_count), 32'd5);
        check("t6_sat_err", 32'(s_err), 32'd3);
        check("t6_sat_idx_wrap", 32'(s_idx), 32'd1);
        check("t6_sat_first", 32'(s_first), 32'd0);
        check("t6_sat_done_pass", 32'({s_done, s_pass}), 32'b10);

        set_vecs(1, 32'b1, 32'b1, 32'b1);
        start_run();
        run_vecs(1, 0);
        check("one_latency", 32'(lat_obs), 32'd2);
        check("one_pass", 32'(pass), 32'h1);
        check("one_vec_idx", 32'(vec_idx), 32'd1);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 20));
            stuck = 1'($urandom_range(1));
            for (int i = 0; i < n; i++) begin
                va[i] = 1'($urandom_range(1));
                ve[i] = 1'($urandom_range(1));
                vc[i] = 1'($urandom_range(1));
            end
            start_run();
            run_vecs(n, 30);
            model(n, e, f);
            check($sformatf("rnd%0d_latency", r), 32'(lat_obs), 32'd2);
            check($sformatf("rnd%0d_err", r), 32'(err_count), 32'(e));
            check($sformatf("rnd%0d_first", r), 32'(first_err_idx), (f < 0) ? 32'hFFFF : 32'(f));
            check($sformatf("rnd%0d_pass", r), 32'(pass), (e == 0) ? 32'h1 : 32'h0);
            check($sformatf("rnd%0d_vec_idx", r), 32'(vec_idx), 32'(n));
            check($sformatf("rnd%0d_sat_err", r), 32'(s_err), (e > 3) ? 32'd3 : 32'(e));
            check($sformatf("rnd%0d_sat_first", r), 32'(s_first), (f < 0) ? 32'd3 : 32'(f % 4));
        end

        stuck = 1'b0;
        start_run();
        vec_val = 1'b1; vec_a = 1'b1; vec_exp = 1'b0; vec_chk = 1'b1; vec_last = 1'b0;
        @(negedge clk);
        vec_val = 1'b0;
        check("t7_pre_dut_a", 32'(dut_a), 32'h1);
        reset = 1'b0;
        #1;
        check("t7_async_dut_a", 32'(dut_a), 32'h0);
        check("t7_async_rdy_busy", 32'({vec_rdy, busy, done}), 32'b000);
        check("t7_async_idx", 32'(vec_idx), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t7_idle", 32'({vec_rdy, busy, done, pass}), 32'b0000);
        check("t7_first", 32'(first_err_idx), 32'hFFFF);
        set_vecs(4, 32'b1010, 32'b1010, 32'b1111);
        start_run();
        run_vecs(4, 20);
        check("t7_clean_pass", 32'(pass), 32'h1);
        check("t7_clean_idx", 32'(vec_idx), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
